decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of in_instr feeding a DEPTH-entry in-order output queue.
// Optional macro DECODE_RV32M_EN adds MUL decode; without it that encoding is reported as illegal.
module decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_instr,
    input  logic [XLEN-1:0]              in_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              out_pc,
    output logic [4:0]                   out_op,
    output logic [4:0]                   out_rd,
    output logic [4:0]                   out_rs1,
    output logic [4:0]                   out_rs2,
    output logic [XLEN-1:0]              out_imm,
    output logic                         out_illegal,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [15:0]                  illegal_cnt
);

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [4:0] OP_ADD     = 5'd0;
    localparam logic [4:0] OP_SUB     = 5'd1;
    localparam logic [4:0] OP_ADDI    = 5'd2;
    localparam logic [4:0] OP_BEQ     = 5'd3;
    localparam logic [4:0] OP_BNE     = 5'd4;
    localparam logic [4:0] OP_BLT     = 5'd5;
    localparam logic [4:0] OP_BGE     = 5'd6;
    localparam logic [4:0] OP_BLTU    = 5'd7;
    localparam logic [4:0] OP_BGEU    = 5'd8;
    localparam logic [4:0] OP_LW      = 5'd9;
    localparam logic [4:0] OP_SW      = 5'd10;
    localparam logic [4:0] OP_JAL     = 5'd11;
    localparam logic [4:0] OP_JALR    = 5'd12;
    localparam logic [4:0] OP_LUI     = 5'd13;
    localparam logic [4:0] OP_AUIPC   = 5'd14;
`ifdef DECODE_RV32M_EN
    localparam logic [4:0] OP_MUL     = 5'd15;
`endif
    localparam logic [4:0] OP_ILLEGAL = 5'd31;

    localparam logic [6:0] OPC_REG    = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      op;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } entry_t;

    // Decode signals
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            legal;
    logic [4:0]      dec_op;
    logic            use_rd;
    logic            use_rs1;
    logic            use_rs2;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    entry_t          dec;

    // Queue state
    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [LW-1:0]   level_q;
    logic [LW-1:0]   level_n;
    logic            ready_q;
    logic            valid_q;
    logic [15:0]     cnt_q;
    logic            push;
    logic            pop;
    entry_t          head;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    // Sign-extended immediates for every format; B/J carry an implicit zero LSB
    assign imm_i = XLEN'($signed(in_instr[31:20]));
    assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));

    // Opcode classification; unrecognised encodings fall through as illegal
    always_comb begin
        legal   = 1'b0;
        dec_op  = OP_ILLEGAL;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        dec_imm = '0;
        case (opcode)
            OPC_REG: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
                    legal  = 1'b1;
                    dec_op = OP_ADD;
                end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
                    legal  = 1'b1;
                    dec_op = OP_SUB;
                end
`ifdef DECODE_RV32M_EN
                else if (funct3 == 3'b000 && funct7 == 7'b0000001) begin
                    legal  = 1'b1;
                    dec_op = OP_MUL;
                end
`endif
            end
            OPC_IMM: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                dec_imm = imm_i;
                if (funct3 == 3'b000) begin
                    legal  = 1'b1;
                    dec_op = OP_ADDI;
                end
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                dec_imm = imm_b;
                legal   = 1'b1;
                case (funct3)
                    3'b000:  dec_op = OP_BEQ;
                    3'b001:  dec_op = OP_BNE;
                    3'b100:  dec_op = OP_BLT;
                    3'b101:  dec_op = OP_BGE;
                    3'b110:  dec_op = OP_BLTU;
                    3'b111:  dec_op = OP_BGEU;
                    default: legal  = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                dec_imm = imm_i;
                if (funct3 == 3'b010) begin
                    legal  = 1'b1;
                    dec_op = OP_LW;
                end
            end
            OPC_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                dec_imm = imm_s;
                if (funct3 == 3'b010) begin
                    legal  = 1'b1;
                    dec_op = OP_SW;
                end
            end
            OPC_JAL: begin
                use_rd  = 1'b1;
                dec_imm = imm_j;
                legal   = 1'b1;
                dec_op  = OP_JAL;
            end
            OPC_JALR: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                dec_imm = imm_i;
                if (funct3 == 3'b000) begin
                    legal  = 1'b1;
                    dec_op = OP_JALR;
                end
            end
            OPC_LUI: begin
                use_rd  = 1'b1;
                dec_imm = imm_u;
                legal   = 1'b1;
                dec_op  = OP_LUI;
            end
            OPC_AUIPC: begin
                use_rd  = 1'b1;
                dec_imm = imm_u;
                legal   = 1'b1;
                dec_op  = OP_AUIPC;
            end
            default: legal = 1'b0;
        endcase
    end

    // Illegal encodings carry no fields at all
    always_comb begin
        dec.pc      = in_pc;
        dec.illegal = !legal;
        dec.op      = legal ? dec_op : OP_ILLEGAL;
        dec.rd      = (legal && use_rd)  ? in_instr[11:7]  : 5'd0;
        dec.rs1     = (legal && use_rs1) ? in_instr[19:15] : 5'd0;
        dec.rs2     = (legal && use_rs2) ? in_instr[24:20] : 5'd0;
        dec.imm     = legal ? dec_imm : '0;
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // in_ready/out_valid are registered, so flush and out_ready never reach in_ready combinationally
    assign push = in_valid && ready_q && !flush;
    assign pop  = valid_q && out_ready && !flush;

    always_comb begin
        level_n = level_q;
        if (flush) begin
            level_n = '0;
        end else if (push && !pop) begin
            level_n = level_q + LW'(1);
        end else if (pop && !push) begin
            level_n = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level_q <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            level_q <= level_n;
            ready_q <= (level_n < LW'(DEPTH));
            valid_q <= (level_n != '0);
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    // Payload storage needs no reset; validity is tracked by level/valid_q
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dec;
    end

    // Saturating count of accepted illegal instructions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (push && dec.illegal && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign head        = mem[rd_ptr];
    assign in_ready    = ready_q;
    assign out_valid   = valid_q;
    assign out_pc      = head.pc;
    assign out_op      = head.op;
    assign out_rd      = head.rd;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_imm     = head.imm;
    assign out_illegal = head.illegal;
    assign level       = level_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: hand-decoded vectors queued on accept, compared at the queue head.
module tb_decode_stage;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned LW    = $clog2(DEPTH + 1);
    localparam int          NV    = 17;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_op;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;
    logic [LW-1:0]   level;
    logic [15:0]     illegal_cnt;

    decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_op     (out_op),
        .out_rd     (out_rd),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .out_imm    (out_imm),
        .out_illegal(out_illegal),
        .level      (level),
        .illegal_cnt(illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        vec_t        v;
    } exp_t;

    vec_t vecs [NV];
    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;
    int   exp_cnt  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive at negedge, compare state against the model, then update the model for the coming edge
    task automatic step(input logic iv, input int idx, input logic [31:0] pc, input logic ordy, input logic fl);
        bit can_push;
        @(negedge clk);
        in_valid  = iv;
        in_instr  = vecs[idx].instr;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_eq("level", 64'(level), 64'(sb.size()));
        check_eq("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        check_eq("in_ready", 64'(in_ready), 64'(sb.size() < DEPTH));
        check_eq("illegal_cnt", 64'(illegal_cnt), 64'(exp_cnt));
        if (sb.size() != 0) begin
            check_eq("head_pc",  64'(out_pc),      64'(sb[0].pc));
            check_eq("head_op",  64'(out_op),      64'(sb[0].v.op));
            check_eq("head_rd",  64'(out_rd),      64'(sb[0].v.rd));
            check_eq("head_rs1", 64'(out_rs1),     64'(sb[0].v.rs1));
            check_eq("head_rs2", 64'(out_rs2),     64'(sb[0].v.rs2));
            check_eq("head_imm", 64'(out_imm),     64'(sb[0].v.imm));
            check_eq("head_ill", 64'(out_illegal), 64'(sb[0].v.ill));
        end
        can_push = iv && (sb.size() < DEPTH);
        if (fl) begin
            sb.delete();
        end else begin
            if (sb.size() != 0 && ordy) void'(sb.pop_front());
            if (can_push) begin
                sb.push_back('{pc: pc, v: vecs[idx]});
                if (vecs[idx].ill && exp_cnt < 16'hFFFF) exp_cnt++;
            end
        end
    endtask

    initial begin
        vecs[0]  = '{32'h00010463, 5'd3,  5'd0, 5'd2, 5'd0, 32'd8,        1'b0};
        vecs[1]  = '{32'h01010113, 5'd2,  5'd2, 5'd2, 5'd0, 32'd16,       1'b0};
        vecs[2]  = '{32'hFFFFFFFF, 5'd31, 5'd0, 5'd0, 5'd0, 32'd0,        1'b1};
`ifdef DECODE_RV32M_EN
        vecs[3]  = '{32'h02208033, 5'd15, 5'd0, 5'd1, 5'd2, 32'd0,        1'b0};
`else
        vecs[3]  = '{32'h02208033, 5'd31, 5'd0, 5'd0, 5'd0, 32'd0,        1'b1};
`endif
        vecs[4]  = '{32'h002081B3, 5'd0,  5'd3, 5'd1, 5'd2, 32'd0,        1'b0};
        vecs[5]  = '{32'h407302B3, 5'd1,  5'd5, 5'd6, 5'd7, 32'd0,        1'b0};
        vecs[6]  = '{32'hFFF00093, 5'd2,  5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0};
        vecs[7]  = '{32'h00812203, 5'd9,  5'd4, 5'd2, 5'd0, 32'd8,        1'b0};
        vecs[8]  = '{32'hFE51AE23, 5'd10, 5'd0, 5'd3, 5'd5, 32'hFFFFFFFC, 1'b0};
        vecs[9]  = '{32'hFF9FF0EF, 5'd11, 5'd1, 5'd0, 5'd0, 32'hFFFFFFF8, 1'b0};
        vecs[10] = '{32'h00008067, 5'd12, 5'd0, 5'd1, 5'd0, 32'd0,        1'b0};
        vecs[11] = '{32'h800003B7, 5'd13, 5'd7, 5'd0, 5'd0, 32'h80000000, 1'b0};
        vecs[12] = '{32'h12345417, 5'd14, 5'd8, 5'd0, 5'd0, 32'h12345000, 1'b0};
        vecs[13] = '{32'hFE2098E3, 5'd4,  5'd0, 5'd1, 5'd2, 32'hFFFFFFF0, 1'b0};
        vecs[14] = '{32'h0041F263, 5'd8,  5'd0, 5'd3, 5'd4, 32'd4,        1'b0};
        vecs[15] = '{32'h00002063, 5'd31, 5'd0, 5'd0, 5'd0, 32'd0,        1'b1};
        vecs[16] = '{32'h0020F1B3, 5'd31, 5'd0, 5'd0, 5'd0, 32'd0,        1'b1};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_level",     64'(level),       64'd0);
        check_eq("rst_out_valid", 64'(out_valid),   64'd0);
        check_eq("rst_in_ready",  64'(in_ready),    64'd1);
        check_eq("rst_ill_cnt",   64'(illegal_cnt), 64'd0);

        // BEQ into empty queue, then fill to DEPTH and hold a third instruction
        step(1'b1, 0,  32'h100, 1'b0, 1'b0);
        step(1'b0, 0,  32'h0,   1'b0, 1'b0);
        step(1'b1, 1,  32'h104, 1'b0, 1'b0);
        step(1'b1, 4,  32'h108, 1'b0, 1'b0);
        step(1'b1, 4,  32'h108, 1'b0, 1'b0);
        step(1'b1, 4,  32'h108, 1'b1, 1'b0);
        step(1'b1, 4,  32'h108, 1'b1, 1'b0);
        step(1'b0, 0,  32'h0,   1'b1, 1'b0);
        step(1'b0, 0,  32'h0,   1'b1, 1'b0);

        // Two all-ones words from a fresh counter
        step(1'b1, 2,  32'h200, 1'b1, 1'b0);
        step(1'b1, 2,  32'h204, 1'b1, 1'b0);
        step(1'b0, 0,  32'h0,   1'b1, 1'b0);
        step(1'b0, 0,  32'h0,   1'b1, 1'b0);
        check_eq("ill_cnt_two", 64'(illegal_cnt), 64'd2);

        // MUL encoding, macro-dependent
        step(1'b1, 3,  32'h300, 1'b1, 1'b0);
        step(1'b0, 0,  32'h0,   1'b1, 1'b0);
        step(1'b0, 0,  32'h0,   1'b1, 1'b0);

        // Flush a full queue while offering an illegal instruction
        step(1'b1, 1,  32'h400, 1'b0, 1'b0);
        step(1'b1, 5,  32'h404, 1'b0, 1'b0);
        step(1'b1, 2,  32'h408, 1'b1, 1'b1);
        step(1'b0, 0,  32'h0,   1'b0, 1'b0);
        step(1'b0, 0,  32'h0,   1'b1, 1'b0);

        // Random traffic over every vector with random backpressure
        for (int n = 0; n < 300; n++) begin
            step(($urandom % 4) != 0, int'($urandom_range(0, NV - 1)),
                 32'h1000 + 32'(n * 4), ($urandom % 3) != 0, ($urandom % 40) == 0);
        end
        for (int n = 0; n < 6; n++) step(1'b0, 0, 32'h0, 1'b1, 1'b0);
        check_eq("drain_level", 64'(level), 64'd0);

        // Asynchronous reset with queued entries and a pending handshake
        step(1'b1, 7,  32'h500, 1'b0, 1'b0);
        step(1'b1, 8,  32'h504, 1'b0, 1'b0);
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_level",     64'(level),       64'd0);
        check_eq("arst_out_valid", 64'(out_valid),   64'd0);
        check_eq("arst_ill_cnt",   64'(illegal_cnt), 64'd0);
        sb.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step(1'b1, 9,  32'h600, 1'b0, 1'b0);
        step(1'b0, 0,  32'h0,   1'b1, 1'b0);
        step(1'b0, 0,  32'h0,   1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
